// File: rtl/spi_cfg_seq.sv
// spi_cfg_seq: walks a configuration table from address 0 and shifts each
// 24-bit entry out over SPI (CPOL=0, MSB first) to one of four devices.
// The run ends after an entry flagged 'last' or at the all-ones address.
//
// Optional feature macro: SPI_READBACK_EN. When it is defined, a word with
// bit 23 set is a read. The block releases the data line after 8 bits,
// captures 16 bits from spi_miso, and presents them on rd_data/rd_valid.
//
// Ports:
//   clk, rst_n           system clock, async active-low reset
//   start, abort         start a run at address 0 / stop the current run
//   busy, done           run in progress / one-cycle end-of-run pulse
//   tbl_addr, tbl_data   synchronous table ROM (one cycle of latency)
//   spi_sclk, spi_csb    serial clock, per-device chip selects (active low)
//   spi_mosi, spi_oe     serial data out, data-line drive enable
//   spi_miso             serial data in (used only with readback)
//   rd_data, rd_valid    readback result (only with SPI_READBACK_EN)
module spi_cfg_seq #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned TBL_AW  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [31:0]       tbl_data,
    output logic              spi_sclk,
    output logic [3:0]        spi_csb,
    output logic              spi_mosi,
    output logic              spi_oe,
    input  logic              spi_miso
`ifdef SPI_READBACK_EN
    ,
    output logic [15:0]       rd_data,
    output logic              rd_valid
`endif
);

    localparam int unsigned CNT_W  = $clog2(2 * CLK_DIV);
    localparam int unsigned WORD_W = 24;

    typedef enum logic [2:0] {IDLE, FETCH, SETUP, SHIFT, HOLD, GAP, FIN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [4:0]         bit_cnt;
    logic [WORD_W-1:0]  shreg;
    logic               last;
    logic               half_end;
    logic               gap_end;

    assign half_end = (cnt == CNT_W'(CLK_DIV - 1));
    assign gap_end  = (cnt == CNT_W'(2 * CLK_DIV - 1));

`ifdef SPI_READBACK_EN
    logic        rd_mode;
    logic [15:0] rd_shift;
    logic        unused_bits;
    assign unused_bits = ^tbl_data[28:24];
`else
    logic        unused_bits;
    assign unused_bits = ^{tbl_data[28:24], spi_miso};
`endif

    // Sequencer: state, timing counters and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            last     <= 1'b0;
            tbl_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            spi_sclk <= 1'b0;
            spi_csb  <= 4'hF;
            spi_mosi <= 1'b0;
            spi_oe   <= 1'b0;
`ifdef SPI_READBACK_EN
            rd_mode  <= 1'b0;
            rd_shift <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef SPI_READBACK_EN
            rd_valid <= 1'b0;
`endif
            if (abort && state != IDLE) begin
                // Abort drops the bus at once; no done pulse
                state    <= IDLE;
                cnt      <= '0;
                busy     <= 1'b0;
                spi_sclk <= 1'b0;
                spi_csb  <= 4'hF;
                spi_mosi <= 1'b0;
                spi_oe   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state    <= FETCH;
                            busy     <= 1'b1;
                            tbl_addr <= '0;
                            cnt      <= '0;
                        end
                    end
                    // First cycle lets the ROM see the address, second latches data
                    FETCH: begin
                        if (cnt == '0) begin
                            cnt <= CNT_W'(1);
                        end else begin
                            cnt      <= '0;
                            bit_cnt  <= '0;
                            shreg    <= tbl_data[23:0];
                            last     <= tbl_data[29];
                            spi_csb  <= ~(4'b0001 << tbl_data[31:30]);
                            spi_mosi <= tbl_data[23];
                            spi_oe   <= 1'b1;
`ifdef SPI_READBACK_EN
                            rd_mode  <= tbl_data[23];
`endif
                            state    <= SETUP;
                        end
                    end
                    SETUP: begin
                        if (half_end) begin
                            cnt      <= '0;
                            spi_sclk <= 1'b1;
                            state    <= SHIFT;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    // bit_cnt counts falling edges; the low phase after the
                    // 24th falling edge completes before HOLD
                    SHIFT: begin
                        if (!half_end) begin
                            cnt <= cnt + CNT_W'(1);
                        end else begin
                            cnt <= '0;
                            if (spi_sclk) begin
                                spi_sclk <= 1'b0;
                                bit_cnt  <= bit_cnt + 5'd1;
                                shreg    <= {shreg[WORD_W-2:0], 1'b0};
                                spi_mosi <= shreg[WORD_W-2];
`ifdef SPI_READBACK_EN
                                if (rd_mode && bit_cnt == 5'd7) begin
                                    spi_oe <= 1'b0;
                                end
`endif
                            end else if (bit_cnt == 5'(WORD_W)) begin
                                state <= HOLD;
`ifdef SPI_READBACK_EN
                                if (rd_mode) begin
                                    rd_data  <= rd_shift;
                                    rd_valid <= 1'b1;
                                end
`endif
                            end else begin
                                spi_sclk <= 1'b1;
`ifdef SPI_READBACK_EN
                                // Rising edges 9..24 carry the 16 read bits
                                if (rd_mode && bit_cnt >= 5'd8) begin
                                    rd_shift <= {rd_shift[14:0], spi_miso};
                                end
`endif
                            end
                        end
                    end
                    HOLD: begin
                        if (half_end) begin
                            cnt      <= '0;
                            spi_csb  <= 4'hF;
                            spi_oe   <= 1'b0;
                            spi_mosi <= 1'b0;
                            state    <= GAP;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    // All-ones address terminates so the address never wraps
                    GAP: begin
                        if (gap_end) begin
                            cnt <= '0;
                            if (last || (&tbl_addr)) begin
                                done  <= 1'b1;
                                state <= FIN;
                            end else begin
                                tbl_addr <= tbl_addr + TBL_AW'(1);
                                state    <= FETCH;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    FIN: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cfg_seq.sv
// Testbench for spi_cfg_seq: table ROM model, random and directed table runs,
// a reference model that expands a table into the expected SPI frames, and a
// monitor that reconstructs frames from the pins and scores them.
`timescale 1ns/1ps
module tb_spi_cfg_seq;

    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned TBL_AW   = 4;
    localparam int          TBL_N    = 1 << TBL_AW;
    localparam int          FULL_LEN = 50 * CLK_DIV;
    // csb-high interval between words: GAP plus the two FETCH cycles
    localparam int          GAP_LEN  = 2 * CLK_DIV + 2;

    typedef struct {
        logic [3:0]  csb;
        int          addr;
        int          len;
        int          nbits;
        logic [23:0] bits;
    } frame_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic [TBL_AW-1:0] tbl_addr;
    logic [31:0]       tbl_data;
    logic              spi_sclk;
    logic [3:0]        spi_csb;
    logic              spi_mosi;
    logic              spi_oe;
    logic              spi_miso = 1'b0;
`ifdef SPI_READBACK_EN
    logic [15:0]       rd_data;
    logic              rd_valid;
`endif

    logic [31:0] rom      [TBL_N];
    logic [15:0] miso_tbl [TBL_N];
    logic [3:0]  csb_tab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    frame_t      exp_frames [$];
    int          exp_done   [$];
    logic [15:0] exp_rd     [$];

    int n_checks = 0;
    int n_fail   = 0;

    spi_cfg_seq #(.CLK_DIV(CLK_DIV), .TBL_AW(TBL_AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .tbl_addr (tbl_addr),
        .tbl_data (tbl_data),
        .spi_sclk (spi_sclk),
        .spi_csb  (spi_csb),
        .spi_mosi (spi_mosi),
        .spi_oe   (spi_oe),
        .spi_miso (spi_miso)
`ifdef SPI_READBACK_EN
        ,
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous table ROM
    always @(posedge clk) tbl_data <= rom[tbl_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expand the table into frames, read results and a done
    task automatic model_run();
        int          a;
        bit          stop;
        logic [31:0] e;
        frame_t      f;
        a    = 0;
        stop = 0;
        while (!stop) begin
            e       = rom[a];
            f.csb   = csb_tab[e[31:30]];
            f.addr  = a;
            f.len   = FULL_LEN;
            f.nbits = 24;
            f.bits  = e[23:0];
            exp_frames.push_back(f);
`ifdef SPI_READBACK_EN
            if (e[23]) exp_rd.push_back(miso_tbl[a]);
`endif
            if (e[29] || a == TBL_N - 1) stop = 1;
            else a++;
        end
        exp_done.push_back(1);
    endtask

    // Monitor state
    logic        in_frame  = 0;
    logic        prev_sclk = 0;
    logic        gap_valid = 0;
    int          gap_len   = 0;
    logic [3:0]  f_csb;
    int          f_addr, f_len, f_bits, f_falls;
    logic [23:0] f_word;
    logic        f_read;
    logic        exp_oe;
    logic [15:0] mw;
    frame_t      mon_e;

    always @(negedge clk) begin
        if (done) begin
            check("done_expected", 32'(exp_done.size() != 0), 32'd1);
            if (exp_done.size() != 0) void'(exp_done.pop_front());
        end
`ifdef SPI_READBACK_EN
        if (rd_valid) begin
            check("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
            if (exp_rd.size() != 0) check("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
        end
`endif
        if (!rst_n) begin
            in_frame  = 0;
            prev_sclk = 0;
            gap_valid = 0;
        end else if (spi_csb != 4'hF) begin
            if (!in_frame) begin
                in_frame = 1;
                f_csb    = spi_csb;
                f_addr   = 32'(tbl_addr);
                f_len    = 0;
                f_bits   = 0;
                f_falls  = 0;
                f_word   = '0;
                f_read   = 0;
                if (gap_valid) check("gap_len", 32'(gap_len), 32'(GAP_LEN));
            end
            check("csb_stable", 32'(spi_csb), 32'(f_csb));
            f_len++;
            if (spi_sclk && !prev_sclk) begin
                if (f_bits == 0) f_read = spi_mosi;
                f_word = {f_word[22:0], spi_mosi};
                f_bits++;
            end
            if (!spi_sclk && prev_sclk) begin
                f_falls++;
`ifdef SPI_READBACK_EN
                // Slave drives its reply after each of falling edges 8..23
                if (f_falls >= 8 && f_falls <= 23) begin
                    mw       = miso_tbl[f_addr];
                    spi_miso = mw[23 - f_falls];
                end
`endif
            end
`ifdef SPI_READBACK_EN
            exp_oe = !(f_read && f_falls >= 8);
`else
            exp_oe = 1'b1;
`endif
            check("oe_in_frame", 32'(spi_oe), 32'(exp_oe));
        end else begin
            if (in_frame) begin
                in_frame = 0;
                check("frame_expected", 32'(exp_frames.size() != 0), 32'd1);
                if (exp_frames.size() != 0) begin
                    mon_e = exp_frames.pop_front();
                    check("frame_csb",  32'(f_csb),  32'(mon_e.csb));
                    check("frame_addr", 32'(f_addr), 32'(mon_e.addr));
                    check("frame_len",  32'(f_len),  32'(mon_e.len));
                    check("frame_bits", 32'(f_bits), 32'(mon_e.nbits));
                    check("frame_word", 32'(f_word), 32'(mon_e.bits));
                end
                gap_len   = 1;
                gap_valid = busy;
            end else begin
                gap_len++;
                if (!busy) gap_valid = 0;
            end
            check("idle_mosi", 32'(spi_mosi), 32'd0);
            check("idle_oe",   32'(spi_oe),   32'd0);
            check("idle_sclk", 32'(spi_sclk), 32'd0);
        end
        prev_sclk = spi_sclk;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fill_table(input int len);
        logic [31:0] w;
        for (int i = 0; i < TBL_N; i++) begin
            w           = $urandom;
            w[29]       = (i == len - 1);
            rom[i]      = w;
            miso_tbl[i] = 16'($urandom);
        end
    endtask

    task automatic check_queues_empty();
        check("frames_left", 32'(exp_frames.size()), 32'd0);
        check("done_left",   32'(exp_done.size()),   32'd0);
        check("rd_left",     32'(exp_rd.size()),     32'd0);
    endtask

    // Run the current table; optionally pulse start again at cycle 'poke'
    task automatic run_table(input int poke);
        int c;
        model_run();
        start = 1;
        tick();
        start = 0;
        check("busy_after_start", 32'(busy), 32'd1);
        c = 0;
        while (busy && c < 20000) begin
            start = (c == poke);
            tick();
            c++;
        end
        start = 0;
        check("run_timeout", 32'(busy), 32'd0);
        tick();
        check_queues_empty();
    endtask

    task automatic wait_rises(input int n, input string name);
        int   rises;
        int   c;
        logic prev;
        rises = 0;
        c     = 0;
        prev  = spi_sclk;
        while (rises < n && c < 2000) begin
            tick();
            if (spi_sclk && !prev) rises++;
            prev = spi_sclk;
            c++;
        end
        check(name, 32'(rises), 32'(n));
    endtask

    task automatic abort_test();
        frame_t      f;
        logic [31:0] w;
        fill_table(3);
        w       = rom[0];
        f.csb   = csb_tab[w[31:30]];
        f.addr  = 0;
        f.len   = CLK_DIV + 2 * CLK_DIV * 9 + 1;
        f.nbits = 10;
        f.bits  = 24'(w[23:14]);
        exp_frames.push_back(f);
        start = 1;
        tick();
        start = 0;
        wait_rises(10, "abort_reach_rise10");
        abort = 1;
        tick();
        abort = 0;
        check("abort_csb",  32'(spi_csb),  32'hF);
        check("abort_sclk", 32'(spi_sclk), 32'd0);
        check("abort_busy", 32'(busy),     32'd0);
        check("abort_oe",   32'(spi_oe),   32'd0);
        repeat (20) tick();
        check("abort_busy_later", 32'(busy), 32'd0);
        exp_rd.delete();
        check_queues_empty();
    endtask

    task automatic reset_mid_shift_test();
        fill_table(2);
        model_run();
        start = 1;
        tick();
        start = 0;
        wait_rises(5, "reset_reach_rise5");
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("rst_async_csb",  32'(spi_csb),  32'hF);
        check("rst_async_sclk", 32'(spi_sclk), 32'd0);
        check("rst_async_mosi", 32'(spi_mosi), 32'd0);
        check("rst_async_oe",   32'(spi_oe),   32'd0);
        check("rst_async_busy", 32'(busy),     32'd0);
        check("rst_async_done", 32'(done),     32'd0);
        check("rst_async_addr", 32'(tbl_addr), 32'd0);
        exp_frames.delete();
        exp_done.delete();
        exp_rd.delete();
        repeat (3) tick();
        rst_n = 1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        start = 0;
        abort = 0;
        for (int i = 0; i < TBL_N; i++) begin
            rom[i]      = '0;
            miso_tbl[i] = '0;
        end
        repeat (3) tick();
        check("reset_busy", 32'(busy),     32'd0);
        check("reset_done", 32'(done),     32'd0);
        check("reset_csb",  32'(spi_csb),  32'hF);
        check("reset_sclk", 32'(spi_sclk), 32'd0);
        check("reset_mosi", 32'(spi_mosi), 32'd0);
        check("reset_oe",   32'(spi_oe),   32'd0);
        check("reset_addr", 32'(tbl_addr), 32'd0);
`ifdef SPI_READBACK_EN
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_rd_data",  32'(rd_data),  32'd0);
`endif
        rst_n = 1;
        repeat (2) tick();

        // Single dac0 word 0x1234AB, last set
        fill_table(1);
        rom[0] = {2'd2, 1'b1, 5'd0, 24'h1234AB};
        run_table(-1);

        // adc0, adc1, dac1 with last on the third
        fill_table(3);
        rom[0][31:30] = 2'd0;
        rom[1][31:30] = 2'd1;
        rom[2][31:30] = 2'd3;
        run_table(-1);

        // start pulsed while busy must not disturb the run
        fill_table(3);
        run_table(300);

        // start and abort together in IDLE
        start = 1;
        abort = 1;
        tick();
        start = 0;
        abort = 0;
        check("start_abort_busy", 32'(busy), 32'd0);
        repeat (10) tick();
        check("start_abort_busy_later", 32'(busy), 32'd0);
        check("start_abort_csb", 32'(spi_csb), 32'hF);

        // abort at the 10th rising edge, then a fresh run from address 0
        abort_test();
        run_table(-1);

        // Randomized tables
        for (int r = 0; r < 6; r++) begin
            fill_table(int'($urandom_range(1, 4)));
            run_table(-1);
        end

        // Reset mid-shift, then recovery
        reset_mid_shift_test();
        fill_table(2);
        run_table(-1);

        // No last flag anywhere: the all-ones address terminates the run
        fill_table(0);
        run_table(-1);

`ifdef SPI_READBACK_EN
        fill_table(1);
        rom[0]      = {2'd0, 1'b1, 5'd0, 24'h800000};
        miso_tbl[0] = 16'hBEEF;
        run_table(-1);
`endif

        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
